// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state constants for the SRAM-backed slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] W_IDLE = 2'b00;
    localparam logic [1:0] W_DATA = 2'b01;
    localparam logic [1:0] W_RESP = 2'b10;

    // Only these lengths form a legal WRAP window; anything else behaves as INCR.
    function automatic logic is_wrap_len(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] step_s;
    logic [31:0] incr_s;
    logic [31:0] win_mask_s;

    // Wrap keeps the upper bits of the (len+1)<<size window and wraps the offset.
    always_comb begin
        step_s     = 32'd1 << size;
        incr_s     = addr + step_s;
        win_mask_s = (({24'd0, len} + 32'd1) << size) - 32'd1;
        next_addr  = incr_s;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_s;
            BURST_WRAP: begin
                if (is_wrap_len(len)) begin
                    next_addr = (addr & ~win_mask_s) | (incr_s & win_mask_s);
                end else begin
                    next_addr = incr_s;
                end
            end
            default: next_addr = incr_s;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style slave over an inferred dual-port word memory; one outstanding
// burst per channel, read-first on same-cycle read/write collisions.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int ID_WIDTH   = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic [1:0]          arlock,
    input  logic [3:0]          arcache,
    input  logic [2:0]          arprot,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_WIDTH-1:0] rid,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic [1:0]          awlock,
    input  logic [3:0]          awcache,
    input  logic [2:0]          awprot,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_WIDTH-1:0] wid,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem_r [DEPTH];
    logic                  reset_done_r;

    logic [0:0]            rd_state_r;
    logic [31:0]           rd_addr_r;
    logic [7:0]            rd_len_r;
    logic [2:0]            rd_size_r;
    logic [1:0]            rd_burst_r;
    logic [7:0]            rd_cnt_r;
    logic [31:0]           rdata_r;
    logic [ID_WIDTH-1:0]   rid_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [31:0]           rd_next_s;
    logic [ADDR_WIDTH-1:0] rd_idx_s;

    logic [1:0]            wr_state_r;
    logic [31:0]           wr_addr_r;
    logic [7:0]            wr_len_r;
    logic [2:0]            wr_size_r;
    logic [1:0]            wr_burst_r;
    logic [7:0]            wr_cnt_r;
    logic                  wr_err_r;
    logic [ID_WIDTH-1:0]   bid_r;
    logic [1:0]            bresp_r;
    logic                  bvalid_r;
    logic [31:0]           wr_next_s;
    logic                  wr_fire_s;

    logic                  unused_s;
    assign unused_s = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    assign arready = reset_done_r && (rd_state_r == R_IDLE);
    assign awready = reset_done_r && (wr_state_r == W_IDLE);
    assign wready  = (wr_state_r == W_DATA);
    assign rvalid  = rvalid_r;
    assign rlast   = rlast_r;
    assign rdata   = rdata_r;
    assign rid     = rid_r;
    assign rresp   = RESP_OKAY;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign bid     = bid_r;

    assign wr_fire_s = (wr_state_r == W_DATA) && wvalid;

    axi_burst_addr u_rd_addr (
        .addr      (rd_addr_r),
        .len       (rd_len_r),
        .size      (rd_size_r),
        .burst     (rd_burst_r),
        .next_addr (rd_next_s)
    );

    axi_burst_addr u_wr_addr (
        .addr      (wr_addr_r),
        .len       (wr_len_r),
        .size      (wr_size_r),
        .burst     (wr_burst_r),
        .next_addr (wr_next_s)
    );

    // Read port address: the AR address when idle, otherwise the following beat.
    always_comb begin
        if (rd_state_r == R_IDLE) begin
            rd_idx_s = araddr[ADDR_WIDTH+1:2];
        end else begin
            rd_idx_s = rd_next_s[ADDR_WIDTH+1:2];
        end
    end

    // Handshake enable one cycle after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reset_done_r <= 1'b0;
        end else begin
            reset_done_r <= 1'b1;
        end
    end

    // Byte-enabled write port; contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (wr_fire_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_r[wr_addr_r[ADDR_WIDTH+1:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: memory is read on AR accept and on every non-last R handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_r <= R_IDLE;
            rd_addr_r  <= 32'd0;
            rd_len_r   <= 8'd0;
            rd_size_r  <= 3'd0;
            rd_burst_r <= 2'd0;
            rd_cnt_r   <= 8'd0;
            rdata_r    <= 32'd0;
            rid_r      <= '0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rd_addr_r  <= araddr;
                        rd_len_r   <= arlen;
                        rd_size_r  <= arsize;
                        rd_burst_r <= arburst;
                        rd_cnt_r   <= 8'd0;
                        rid_r      <= arid;
                        rdata_r    <= mem_r[rd_idx_s];
                        rvalid_r   <= 1'b1;
                        rlast_r    <= (arlen == 8'd0);
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_r) begin
                            rvalid_r   <= 1'b0;
                            rlast_r    <= 1'b0;
                            rd_state_r <= R_IDLE;
                        end else begin
                            rd_addr_r <= rd_next_s;
                            rdata_r   <= mem_r[rd_idx_s];
                            rd_cnt_r  <= rd_cnt_r + 8'd1;
                            rlast_r   <= ((rd_cnt_r + 8'd1) == rd_len_r);
                        end
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    rvalid_r   <= 1'b0;
                    rlast_r    <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM: the beat counter saturates and an overrun latches a sticky error.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_r <= W_IDLE;
            wr_addr_r  <= 32'd0;
            wr_len_r   <= 8'd0;
            wr_size_r  <= 3'd0;
            wr_burst_r <= 2'd0;
            wr_cnt_r   <= 8'd0;
            wr_err_r   <= 1'b0;
            bid_r      <= '0;
            bresp_r    <= RESP_OKAY;
            bvalid_r   <= 1'b0;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        wr_addr_r  <= awaddr;
                        wr_len_r   <= awlen;
                        wr_size_r  <= awsize;
                        wr_burst_r <= awburst;
                        wr_cnt_r   <= 8'd0;
                        wr_err_r   <= 1'b0;
                        bid_r      <= awid;
                        wr_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        wr_addr_r <= wr_next_s;
                        if (wr_cnt_r != 8'hFF) begin
                            wr_cnt_r <= wr_cnt_r + 8'd1;
                        end
                        if (wlast) begin
                            bresp_r    <= (wr_err_r || (wr_cnt_r != wr_len_r)) ? RESP_SLVERR : RESP_OKAY;
                            bvalid_r   <= 1'b1;
                            wr_state_r <= W_RESP;
                        end else if (wr_cnt_r >= wr_len_r) begin
                            wr_err_r <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_r   <= 1'b0;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    bvalid_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized self-checking bench for axi_sram_slave against a word-array reference model.
`timescale 1ns/1ps
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [16384];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic [31:0] rd_got  [$];

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_WIDTH(14), .ID_WIDTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd16384);
    endfunction

    // Burst address stepping written arithmetically from the protocol rules.
    function automatic logic [31:0] model_next(input logic [31:0] a, input int len,
                                               input int size, input int burst);
        logic [31:0] step, win, base;
        step = 32'd1 << size;
        if (burst == 0) return a;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            win  = step * (len + 1);
            base = (a / win) * win;
            return base + ((a - base + step) % win);
        end
        return a + step;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int nbeats);
        logic [31:0] a;
        logic [1:0]  exp_resp;
        int t, k;
        @(negedge aclk);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        chk("aw_accept", {31'd0, awready}, 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
            wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            chk("w_accept", {31'd0, wready}, 32'd1);
            k = widx(a);
            for (int b = 0; b < 4; b++)
                if (wq_strb[i][b]) ref_mem[k][8*b +: 8] = wq_data[i][8*b +: 8];
            a = model_next(a, int'(len), int'(size), int'(burst));
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_resp = (nbeats == int'(len) + 1) ? 2'b00 : 2'b10;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        chk("bid", {28'd0, bid}, {28'd0, id});
        chk("wready_in_resp", {31'd0, wready}, 32'd0);
        repeat ($urandom_range(0, 2)) @(negedge aclk);
        chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("b_done", {31'd0, bvalid}, 32'd0);
        chk("aw_after_b", {31'd0, awready}, 32'd1);
    endtask

    // mode 0: rready always 1, 1: random, 2: toggling
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int mode);
        logic [31:0] a, sd;
        logic        sl, stalled;
        int t, beat;
        @(negedge aclk);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        chk("ar_accept", {31'd0, arready}, 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        a = addr; beat = 0; t = 0; stalled = 1'b0; sd = 32'd0; sl = 1'b0;
        rd_got.delete();
        while (beat <= int'(len) && t < 3000) begin
            chk("rvalid_cont", {31'd0, rvalid}, 32'd1);
            if (stalled) begin
                chk("stall_rdata", rdata, sd);
                chk("stall_rlast", {31'd0, rlast}, {31'd0, sl});
            end
            chk("rdata", rdata, ref_mem[widx(a)]);
            chk("rid", {28'd0, rid}, {28'd0, id});
            chk("rresp", {30'd0, rresp}, 32'd0);
            chk("rlast", {31'd0, rlast}, (beat == int'(len)) ? 32'd1 : 32'd0);
            case (mode)
                0:       rready = 1'b1;
                1:       rready = 1'(($urandom_range(0, 1)));
                default: rready = t[0];
            endcase
            if (rready) begin
                rd_got.push_back(rdata);
                a = model_next(a, int'(len), int'(size), int'(burst));
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1; sd = rdata; sl = rlast;
            end
            @(negedge aclk);
            t++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) chk("r_timeout", 32'd0, 32'd1);
        chk("rvalid_after_last", {31'd0, rvalid}, 32'd0);
        chk("ar_after_last", {31'd0, arready}, 32'd1);
    endtask

    task automatic fill_random(input int n, input logic full);
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i < n; i++) begin
            wq_data.push_back($urandom);
            wq_strb.push_back(full ? 4'hF : 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          wrap_idx [4];
        int          t;

        aresetn = 1'b0;
        arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
        arlock = 2'd0; arcache = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0;
        awlock = 2'd0; awcache = 4'd0; awprot = 3'd0; awvalid = 1'b0;
        wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        repeat (3) @(negedge aclk);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rid", {28'd0, rid}, 32'd0);
        chk("rst_bid", {28'd0, bid}, 32'd0);
        chk("rst_bresp", {30'd0, bresp}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("reset_done_ar", {31'd0, arready}, 32'd1);
        chk("reset_done_aw", {31'd0, awready}, 32'd1);

        // Prefill words 0..255 with a maximum-length INCR burst.
        fill_random(256, 1'b1);
        do_write(32'h0, 8'd255, 3'd2, 2'd1, 4'd3, 256);

        // Single write and read through an aliased high address.
        wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
        do_write(32'h1FC00010, 8'd0, 3'd2, 2'd1, 4'd5, 1);
        do_read(32'h1FC00010, 8'd0, 3'd2, 2'd1, 4'd9, 0);
        chk("single_rdata", rd_got[0], 32'hDEADBEEF);
        chk("alias_word4", ref_mem[4], 32'hDEADBEEF);

        do_read(32'h20, 8'd3, 3'd2, 2'd1, 4'd1, 0);
        for (int i = 0; i < 4; i++) chk("refill_word", rd_got[i], ref_mem[8 + i]);

        wrap_idx = '{10, 11, 8, 9};
        do_read(32'h28, 8'd3, 3'd2, 2'd2, 4'd2, 0);
        for (int i = 0; i < 4; i++) chk("wrap_order", rd_got[i], ref_mem[wrap_idx[i]]);

        do_read(32'h40, 8'd7, 3'd2, 2'd1, 4'd6, 2);
        do_read(32'h80, 8'd15, 3'd2, 2'd2, 4'd7, 1);

        wq_data = '{32'h11223344}; wq_strb = '{4'hF};
        do_write(32'h100, 8'd0, 3'd2, 2'd1, 4'd1, 1);
        wq_data = '{32'hAABBCCDD}; wq_strb = '{4'h5};
        do_write(32'h100, 8'd0, 3'd2, 2'd1, 4'd1, 1);
        do_read(32'h100, 8'd0, 3'd2, 2'd1, 4'd1, 0);
        chk("partial_strb", rd_got[0], 32'h11BB33DD);

        fill_random(2, 1'b1);
        do_write(32'h140, 8'd3, 3'd2, 2'd1, 4'd8, 2);
        fill_random(4, 1'b1);
        do_write(32'h180, 8'd1, 3'd2, 2'd1, 4'd4, 4);
        do_read(32'h180, 8'd3, 3'd2, 2'd1, 4'd4, 1);

        // Reset in the middle of a stalled read burst.
        @(negedge aclk);
        araddr = 32'h40; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arid = 4'hA; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        @(negedge aclk);
        arvalid = 1'b0;
        chk("pre_reset_rvalid", {31'd0, rvalid}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_reset_arready", {31'd0, arready}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        do_read(32'h48, 8'd3, 3'd2, 2'd1, 4'hB, 0);

        for (int it = 0; it < 25; it++) begin
            size  = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0:       len = 8'd0;
                1:       len = 8'd1;
                2:       len = 8'd3;
                3:       len = 8'd7;
                4:       len = 8'd15;
                default: len = 8'($urandom_range(0, 20));
            endcase
            addr = 32'($urandom_range(0, 32'h2FF));
            addr = addr & ~((32'd1 << size) - 32'd1);
            fill_random(int'(len) + 1, 1'b0);
            do_write(addr, len, size, burst, 4'($urandom_range(0, 15)), int'(len) + 1);
            do_read(addr, len, size, burst, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3-style slave backed by an on-chip word-addressed memory.
- Sits directly downstream of the CPU top's AXI master port in the SoC simulation/FPGA build.
- Serves I/D cache line refills, writebacks and uncached single-beat accesses.
- Read and write channels are independent. Each channel handles one outstanding burst.

Parameters:
ADDR_WIDTH, 14, word-address bits (memory depth 2^ADDR_WIDTH 32-bit words)
ID_WIDTH, 4, AXI ID width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  ID_WIDTH  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  bytes per beat = 1<<arsize (max 2)
arburst  in  2  0 FIXED, 1 INCR, 2 WRAP
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  latched arid
rdata  out  32  read data
rresp  out  2  always OKAY
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready
awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/32/8/3/2  same meaning as AR fields
awlock/awcache/awprot  in  2/4/3  ignored
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  ID_WIDTH  ignored
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  latched awid
bresp  out  2  OKAY or SLVERR
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- All state uses aclk, with asynchronous reset on aresetn low. Memory contents are not reset.
- Reset values: arready=0, awready=0, rvalid=0, rlast=0, wready=0, bvalid=0, rdata=0, rid=0, bid=0, bresp=0.
- A reset_done flop (reset 0, set 1 one cycle after release) gates arready/awready.
- Reset during a burst returns both FSMs to IDLE. The burst is abandoned and no response is issued.
- Word index = addr[ADDR_WIDTH+1:2]. Upper bits alias. No decode error is generated.
- Next address (all beats):
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: increment within the aligned (len+1)<<size window. Legal len 1/3/7/15. Other len is treated as INCR.
- Read FSM:
  - R_IDLE: arready=reset_done. AR handshake at cycle T latches id/len/size/burst, issues memory read of araddr, and enters R_DATA.
  - R_DATA: rvalid=1 from T+1. rdata is the full word; the master selects byte lanes. rlast=1 when beat count == len.
  - rdata/rid/rlast hold stable while rvalid & !rready.
  - On an R handshake of a non-last beat, the memory read of the next address is issued in the same cycle. The next beat is valid the following cycle, giving full throughput of one beat per cycle.
  - On a last-beat handshake: rvalid=0 next cycle and return to R_IDLE. arready=1 in that next cycle.
- Write FSM:
  - W_IDLE: awready=reset_done, wready=0. W beats arriving before AW are not accepted.
  - AW handshake latches the fields and enters W_DATA (wready=1).
  - Each W handshake writes the bytes of wstrb at the current word, then advances the address. wstrb=0 is a no-op beat.
  - A W handshake with wlast=1 enters W_RESP. If the beat count != len+1, bresp=SLVERR (2'b10); otherwise OKAY.
  - More than len+1 beats without wlast: extra beats are accepted and still written (address keeps advancing), and bresp=SLVERR.
  - W_RESP: bvalid=1 and bid=latched awid, held until bready. Then W_IDLE, with awready=1 the cycle after the B handshake.
- Simultaneous read and write to the same word in one cycle: the read returns the old data (read-first). The write is visible to reads issued on later cycles.
- Beat counter is 8 bits and cannot overflow: len max 255, and the overrun case saturates with the error sticky.

Decomposition:
- Package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, read and write state enums.
- Sub-module axi_burst_addr (combinational next-address from addr/len/size/burst), instantiated once per channel.
- Memory is an inferred dual-port array inside the top.

Test Plan:
- Single write then read: AW 0x1FC00010 len0 size2 INCR, W 0xDEADBEEF strb 0xF -> bresp OKAY. Then AR same address -> rdata 0xDEADBEEF with rlast=1 at T+1.
- Line refill: AR 0x00000020 len3 INCR, rready held 1 -> four beats on consecutive cycles of words 8..11, rlast only on beat 4, arready 1 the next cycle.
- WRAP: AR 0x00000028 len3 size2 -> word order 10,11,8,9.
- Backpressure: rready toggled 1/0 during a burst -> rdata/rid/rlast stable while stalled, no beats lost or duplicated.
- Partial strobe: write 0x11223344 strb 0xF, then 0xAABBCCDD strb 0x5 -> readback 0x11BB33DD.
- Error and reset: AW len3 with wlast on beat 2 -> bresp 2'b10. Then drop aresetn mid read burst -> rvalid 0 immediately, and after release a new AR is accepted with correct data.
